// File: rtl/fetch_pkg.sv
// Shared types for the IF/ID fetch stage: FSM state encoding, IF/ID register
// payload and default widths/NOP.
package fetch_pkg;

    localparam int          IF_PC_W           = 16;
    localparam int          IF_INSTR_W        = 32;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        KILL = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic                  valid;
        logic [IF_INSTR_W-1:0] instr;
        logic [IF_PC_W-1:0]    pc;
        logic [IF_PC_W-1:0]    inc_pc;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > hold > load > bubble.
// Flush and bubble squash valid/instr only; pc fields keep their last value.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [IF_INSTR_W-1:0] NOP = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   hold,
    input  logic   load,
    input  if_id_t din,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.valid  <= 1'b0;
            q.instr  <= NOP;
            q.pc     <= '0;
            q.inc_pc <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= NOP;
        end else if (!hold) begin
            if (load) begin
                q <= din;
            end else begin
                q.valid <= 1'b0;
                q.instr <= NOP;
            end
        end
    end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, skid buffer for decode
// back-pressure, flush squashing. Optional perf counters under IF_PERF_CNT_EN.
module if_id_fetch_stage
    import fetch_pkg::*;
#(
    // The IF/ID payload struct is sized by the package widths; keep these equal.
    parameter int                     PC_WIDTH    = IF_PC_W,
    parameter int                     INSTR_WIDTH = IF_INSTR_W,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic [PC_WIDTH-1:0]    inc_pc,
    output logic                   pc_en,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_rvalid,
    input  logic                   id_stall,
    input  logic                   flush,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stall_cycles,
`endif
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [PC_WIDTH-1:0]    id_inc_pc
);

    fetch_state_t            state, state_nxt;
    logic [PC_WIDTH-1:0]     req_pc, req_inc_pc;
    logic [INSTR_WIDTH-1:0]  skid_instr;
    logic                    skid_cap;
    logic                    ld;
    if_id_t                  ld_d, q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // pc_en and ld are the same event: an instruction accepted by decode.
    always_comb begin
        state_nxt = state;
        pc_en     = 1'b0;
        ld        = 1'b0;
        skid_cap  = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  state_nxt = flush ? KILL : WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    if (flush) begin
                        state_nxt = REQ;
                    end else if (!id_stall) begin
                        ld        = 1'b1;
                        pc_en     = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        skid_cap  = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (flush) begin
                    state_nxt = KILL;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nxt = REQ;
                end else if (!id_stall) begin
                    ld        = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = REQ;
                end
            end
            // A flush here still waits out the pending response.
            KILL: if (imem_rvalid) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc     <= '0;
            req_inc_pc <= '0;
        end else if (state == REQ) begin
            req_pc     <= pc;
            req_inc_pc <= inc_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           skid_instr <= '0;
        else if (skid_cap) skid_instr <= imem_rdata;
    end

    always_comb begin
        ld_d.valid  = 1'b1;
        ld_d.instr  = IF_INSTR_W'((state == HOLD) ? skid_instr : imem_rdata);
        ld_d.pc     = IF_PC_W'(req_pc);
        ld_d.inc_pc = IF_PC_W'(req_inc_pc);
    end

    if_id_reg #(
        .NOP (IF_INSTR_W'(NOP_INSTR))
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .hold  (id_stall),
        .load  (ld),
        .din   (ld_d),
        .q     (q)
    );

    assign id_valid  = q.valid;
    assign id_instr  = INSTR_WIDTH'(q.instr);
    assign id_pc     = PC_WIDTH'(q.pc);
    assign id_inc_pc = PC_WIDTH'(q.inc_pc);

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (pc_en) perf_fetched <= perf_fetched + 32'd1;
            if (state == HOLD || (state == WAIT && !imem_rvalid))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
